// File: rtl/crosswalk_arbiter.sv
// Pedestrian crosswalk arbiter: latches north/west button presses and serves them round-robin over req/ack/done.
// Optional two-flop button synchronizer enabled by defining XWALK_SYNC_EN.
module crosswalk_arbiter #(
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       north_btn,
  input  logic       west_btn,
  output logic       svc_req,
  output logic       svc_sel,
  input  logic       svc_ack,
  input  logic       svc_done,
  output logic [1:0] pend,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVE, HOLDOFF} state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       prev_q;
  logic [1:0]       clr;
  logic [1:0]       btn_raw;
  logic [1:0]       btn_s;
  logic [1:0]       btn_rise;

  assign btn_raw = {west_btn, north_btn};

`ifdef XWALK_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_q[gi] <= 1'b0;
          sync2_q[gi] <= 1'b0;
        end else begin
          sync1_q[gi] <= btn_raw[gi];
          sync2_q[gi] <= sync1_q[gi];
        end
      end
    end
  endgenerate

  assign btn_s = sync2_q;
`else
  assign btn_s = btn_raw;
`endif

  // prev resets to 0 so a button held through reset release yields one edge
  assign btn_rise = btn_s & ~prev_q;
  // a new edge wins over the ack-time clear of the same direction
  assign pend_d   = (pend_q & ~clr) | btn_rise;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    clr     = 2'b00;
    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          sel_d   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (svc_ack) begin
          req_d   = 1'b0;
          clr     = sel_q ? 2'b10 : 2'b01;
          last_d  = sel_q;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (svc_done) begin
          cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      pend_q  <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      prev_q  <= btn_s;
    end
  end

  assign svc_req = req_q;
  assign svc_sel = sel_q;
  assign pend    = pend_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_crosswalk_arbiter.sv
// Directed bench for crosswalk_arbiter (default build, HOLDOFF_CYCLES=4).
// Observed vector is {svc_req, svc_sel, pend[1], pend[0], busy}.
module tb_crosswalk_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       north_btn = 1'b0;
  logic       west_btn = 1'b0;
  logic       svc_ack = 1'b0;
  logic       svc_done = 1'b0;
  logic       svc_req;
  logic       svc_sel;
  logic [1:0] pend;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] obs;

  crosswalk_arbiter #(.HOLDOFF_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .north_btn (north_btn),
    .west_btn  (west_btn),
    .svc_req   (svc_req),
    .svc_sel   (svc_sel),
    .svc_ack   (svc_ack),
    .svc_done  (svc_done),
    .pend      (pend),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    north_btn = 1'b0;
    west_btn  = 1'b0;
    svc_ack   = 1'b0;
    svc_done  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic finish_service();
    svc_ack = 1'b1;
    step();
    svc_ack  = 1'b0;
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL reset_async: got %b expected %b", obs, 5'b00000); end
    step();
    reset_n = 1'b1;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, 5'b00000); end
    $display("test_reset done");
  endtask

  task automatic test_single_north();
    logic [4:0] exp_v [7];
    exp_v = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    svc_ack   = 1'b1;
    north_btn = 1'b1;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL single_pend: got %b expected %b", obs, 5'b00010); end
    north_btn = 1'b0;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b10011) begin errors++; $display("FAIL single_req: got %b expected %b", obs, 5'b10011); end
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL single_ack: got %b expected %b", obs, 5'b00001); end
    svc_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      svc_done = 1'b0;
      obs = {svc_req, svc_sel, pend, busy}; checks++;
      if (obs !== exp_v[i]) begin errors++; $display("FAIL single_holdoff[%0d]: got %b expected %b", i, obs, exp_v[i]); end
    end
    svc_ack = 1'b0;
    $display("test_single_north done");
  endtask

  task automatic test_tie();
    do_reset();
    north_btn = 1'b1;
    west_btn  = 1'b1;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00110) begin errors++; $display("FAIL tie_pend: got %b expected %b", obs, 5'b00110); end
    north_btn = 1'b0;
    west_btn  = 1'b0;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b10111) begin errors++; $display("FAIL tie_first_north: got %b expected %b", obs, 5'b10111); end
    svc_ack = 1'b1;
    step();
    svc_ack = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00101) begin errors++; $display("FAIL tie_ack1: got %b expected %b", obs, 5'b00101); end
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    repeat (3) step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00101) begin errors++; $display("FAIL tie_holdoff_end: got %b expected %b", obs, 5'b00101); end
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00100) begin errors++; $display("FAIL tie_idle: got %b expected %b", obs, 5'b00100); end
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b11101) begin errors++; $display("FAIL tie_then_west: got %b expected %b", obs, 5'b11101); end
    svc_ack = 1'b1;
    step();
    svc_ack = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b01001) begin errors++; $display("FAIL tie_ack2: got %b expected %b", obs, 5'b01001); end
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    repeat (4) step();
    north_btn = 1'b1;
    west_btn  = 1'b1;
    step();
    north_btn = 1'b0;
    west_btn  = 1'b0;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b10111) begin errors++; $display("FAIL tie_second_north: got %b expected %b", obs, 5'b10111); end
    finish_service();
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b11101) begin errors++; $display("FAIL tie_second_west: got %b expected %b", obs, 5'b11101); end
    finish_service();
    $display("test_tie done");
  endtask

  task automatic test_ack_stall();
    north_btn = 1'b1;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b01010) begin errors++; $display("FAIL stall_pend: got %b expected %b", obs, 5'b01010); end
    north_btn = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      north_btn = (i % 2 == 0);
      step();
      obs = {svc_req, svc_sel, pend, busy}; checks++;
      if (obs !== 5'b10011) begin errors++; $display("FAIL stall_hold[%0d]: got %b expected %b", i, obs, 5'b10011); end
    end
    north_btn = 1'b0;
    svc_ack   = 1'b1;
    step();
    svc_ack = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL stall_ack: got %b expected %b", obs, 5'b00001); end
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    repeat (5) step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL stall_single_service: got %b expected %b", obs, 5'b00000); end
    $display("test_ack_stall done");
  endtask

  task automatic test_edge_in_ack();
    north_btn = 1'b1;
    step();
    north_btn = 1'b0;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b10011) begin errors++; $display("FAIL eack_req: got %b expected %b", obs, 5'b10011); end
    svc_ack   = 1'b1;
    north_btn = 1'b1;
    step();
    svc_ack   = 1'b0;
    north_btn = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00011) begin errors++; $display("FAIL eack_set_wins: got %b expected %b", obs, 5'b00011); end
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    repeat (4) step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL eack_idle: got %b expected %b", obs, 5'b00010); end
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b10011) begin errors++; $display("FAIL eack_reserve: got %b expected %b", obs, 5'b10011); end
    finish_service();
    $display("test_edge_in_ack done");
  endtask

  task automatic test_stray();
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL stray_done_idle: got %b expected %b", obs, 5'b00000); end
    svc_ack = 1'b1;
    step();
    svc_ack = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL stray_ack_idle: got %b expected %b", obs, 5'b00000); end
    north_btn = 1'b1;
    step();
    north_btn = 1'b0;
    step();
    svc_ack = 1'b1;
    step();
    step();
    svc_ack = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL stray_ack_serve: got %b expected %b", obs, 5'b00001); end
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    repeat (3) step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00001) begin errors++; $display("FAIL stray_holdoff: got %b expected %b", obs, 5'b00001); end
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL stray_idle: got %b expected %b", obs, 5'b00000); end
    $display("test_stray done");
  endtask

  task automatic test_reset_mid();
    west_btn = 1'b1;
    step();
    west_btn = 1'b0;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b11101) begin errors++; $display("FAIL rmid_req_west: got %b expected %b", obs, 5'b11101); end
    svc_ack = 1'b1;
    step();
    svc_ack  = 1'b0;
    west_btn = 1'b1;
    step();
    west_btn = 1'b0;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b01101) begin errors++; $display("FAIL rmid_serve_pend: got %b expected %b", obs, 5'b01101); end
    #2;
    reset_n = 1'b0;
    #1;
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL rmid_async: got %b expected %b", obs, 5'b00000); end
    step();
    reset_n = 1'b1;
    repeat (5) step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL rmid_quiet: got %b expected %b", obs, 5'b00000); end
    $display("test_reset_mid done");
  endtask

  task automatic test_held_through_reset();
    reset_n   = 1'b0;
    north_btn = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00010) begin errors++; $display("FAIL held_pend: got %b expected %b", obs, 5'b00010); end
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b10011) begin errors++; $display("FAIL held_req: got %b expected %b", obs, 5'b10011); end
    finish_service();
    step();
    obs = {svc_req, svc_sel, pend, busy}; checks++;
    if (obs !== 5'b00000) begin errors++; $display("FAIL held_single: got %b expected %b", obs, 5'b00000); end
    north_btn = 1'b0;
    step();
    $display("test_held_through_reset done");
  endtask

  initial begin
    test_reset();
    test_single_north();
    test_tie();
    test_ack_stall();
    test_edge_in_ack();
    test_stray();
    test_reset_mid();
    test_held_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
